// File: rtl/dtc_vote_accum.sv
// Majority-vote accumulator: counts per-class decisions over a window, scans for the
// winner and presents it over valid/ready. Optional confidence/tie outputs: DTC_VOTE_CONF_EN.
module dtc_vote_accum #(
  parameter int unsigned WIN = 16,
  parameter int unsigned CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_class,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_class,
  output logic [CW-1:0] out_nsamp
`ifdef DTC_VOTE_CONF_EN
  ,
  output logic [CW-1:0] out_conf,
  output logic          out_tie
`endif
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q [8];
  logic [CW-1:0] cnt_d [8];
  logic [CW-1:0] nsamp_q, nsamp_d;
  logic [CW-1:0] nsamp_inc;
  logic [2:0]    scan_q, scan_d;
  logic [2:0]    best_q, best_d;
  logic [CW-1:0] best_cnt_q, best_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [2:0]    out_class_q, out_class_d;
  logic [CW-1:0] out_nsamp_q, out_nsamp_d;
  logic          accept;
`ifdef DTC_VOTE_CONF_EN
  logic          tie_q, tie_d;
  logic [CW-1:0] out_conf_q, out_conf_d;
  logic          out_tie_q, out_tie_d;
`endif

  always_comb begin
    state_d     = state_q;
    nsamp_d     = nsamp_q;
    scan_d      = scan_q;
    best_d      = best_q;
    best_cnt_d  = best_cnt_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_nsamp_d = out_nsamp_q;
    for (int unsigned i = 0; i < 8; i++) cnt_d[i] = cnt_q[i];
`ifdef DTC_VOTE_CONF_EN
    tie_d      = tie_q;
    out_conf_d = out_conf_q;
    out_tie_d  = out_tie_q;
`endif
    accept    = in_valid && in_ready_q;
    nsamp_inc = nsamp_q + CW'(1);

    case (state_q)
      ACCUM: begin
        if (accept) begin
          cnt_d[in_class] = cnt_q[in_class] + CW'(1);
          nsamp_d         = nsamp_inc;
        end
        // A flush only closes a window that holds at least one sample
        if ((accept && nsamp_inc == CW'(WIN)) || (flush && (accept || nsamp_q != '0))) begin
          state_d = RESOLVE;
          scan_d  = '0;
        end
      end
      RESOLVE: begin
        // Strict compare keeps the lowest index on ties
        if (cnt_q[scan_q] > best_cnt_q) begin
          best_d     = scan_q;
          best_cnt_d = cnt_q[scan_q];
`ifdef DTC_VOTE_CONF_EN
          tie_d      = 1'b0;
        end else if (cnt_q[scan_q] == best_cnt_q && best_cnt_q != '0) begin
          tie_d      = 1'b1;
`endif
        end
        scan_d = scan_q + 3'd1;
        if (scan_q == 3'd7) begin
          out_class_d = best_d;
          out_nsamp_d = nsamp_q;
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
`ifdef DTC_VOTE_CONF_EN
          out_conf_d  = best_cnt_d;
          out_tie_d   = tie_d;
`endif
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          for (int unsigned i = 0; i < 8; i++) cnt_d[i] = '0;
          nsamp_d     = '0;
          best_d      = '0;
          best_cnt_d  = '0;
          out_valid_d = 1'b0;
          state_d     = ACCUM;
`ifdef DTC_VOTE_CONF_EN
          tie_d       = 1'b0;
`endif
        end
      end
      default: state_d = ACCUM;
    endcase

    in_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      for (int unsigned i = 0; i < 8; i++) cnt_q[i] <= '0;
      nsamp_q     <= '0;
      scan_q      <= '0;
      best_q      <= '0;
      best_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_nsamp_q <= '0;
`ifdef DTC_VOTE_CONF_EN
      tie_q       <= 1'b0;
      out_conf_q  <= '0;
      out_tie_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      for (int unsigned i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      nsamp_q     <= nsamp_d;
      scan_q      <= scan_d;
      best_q      <= best_d;
      best_cnt_q  <= best_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_nsamp_q <= out_nsamp_d;
`ifdef DTC_VOTE_CONF_EN
      tie_q       <= tie_d;
      out_conf_q  <= out_conf_d;
      out_tie_q   <= out_tie_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_nsamp = out_nsamp_q;
`ifdef DTC_VOTE_CONF_EN
  assign out_conf  = out_conf_q;
  assign out_tie   = out_tie_q;
`endif

endmodule
